// File: rtl/lc3b_mem_bridge.sv
// LC-3b MAR/MDR memory port to registered pmem handshake bridge.
// Has a one-word read buffer, a saturating hit counter and a pmem timeout with a sticky error flag.
`timescale 1ns/1ps
module lc3b_mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  input  logic        inval,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        mem_err,
  output logic [15:0] hit_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIT    = 3'd1,
    PREAD  = 3'd2,
    PWRITE = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_r;
  logic [15:0]      buf_data_r;
  logic [14:0]      buf_tag_r;
  logic             buf_valid_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic buf_hit_s;
  logic tag_match_s;
  logic timeout_s;
  logic unused_addr_lsb_s;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_data,
                                              input logic [15:0] new_data,
                                              input logic [1:0]  be);
    merge_bytes = {be[1] ? new_data[15:8] : old_data[15:8],
                   be[0] ? new_data[7:0]  : old_data[7:0]};
  endfunction

  // Memory is word addressed; the byte offset only matters to the CPU.
  assign unused_addr_lsb_s = mem_address[0];

  // Buffer lookup for the incoming request, tag check for the write in flight, wait expiry.
  always_comb begin
    buf_hit_s   = buf_valid_r && (buf_tag_r == mem_address[15:1]);
    tag_match_s = buf_valid_r && (buf_tag_r == pmem_address[15:1]);
    timeout_s   = TO_EN && (wait_cnt_r == TO_LAST);
  end

  // Bridge FSM, registered outputs and read buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      mem_rdata        <= 16'h0000;
      mem_resp         <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= 16'h0000;
      pmem_wdata       <= 16'h0000;
      pmem_byte_enable <= 2'b00;
      mem_err          <= 1'b0;
      hit_count        <= 16'h0000;
      buf_data_r       <= 16'h0000;
      buf_tag_r        <= 15'h0000;
      buf_valid_r      <= 1'b0;
      wait_cnt_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_resp   <= 1'b0;
          wait_cnt_r <= '0;
          if (mem_write) begin
            pmem_address     <= {mem_address[15:1], 1'b0};
            pmem_wdata       <= mem_wdata;
            pmem_byte_enable <= mem_byte_enable;
            pmem_write       <= 1'b1;
            state_r          <= PWRITE;
          end else if (mem_read) begin
            if (buf_hit_s) begin
              state_r <= HIT;
            end else begin
              pmem_address <= {mem_address[15:1], 1'b0};
              pmem_read    <= 1'b1;
              state_r      <= PREAD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        HIT: begin
          mem_rdata <= buf_data_r;
          hit_count <= (hit_count == 16'hFFFF) ? hit_count : hit_count + 16'd1;
          mem_resp  <= 1'b1;
          state_r   <= RESP;
        end
        PREAD: begin
          // A response arriving on the final wait cycle still completes normally.
          if (pmem_resp) begin
            mem_rdata   <= pmem_rdata;
            buf_data_r  <= pmem_rdata;
            buf_tag_r   <= pmem_address[15:1];
            buf_valid_r <= 1'b1;
            pmem_read   <= 1'b0;
            mem_resp    <= 1'b1;
            wait_cnt_r  <= '0;
            state_r     <= RESP;
          end else if (timeout_s) begin
            mem_rdata  <= 16'h0000;
            mem_err    <= 1'b1;
            pmem_read  <= 1'b0;
            mem_resp   <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= RESP;
          end else begin
            wait_cnt_r <= (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + CNT_W'(1);
          end
        end
        PWRITE: begin
          if (pmem_resp) begin
            if (tag_match_s) begin
              buf_data_r <= merge_bytes(buf_data_r, pmem_wdata, pmem_byte_enable);
            end else begin
              buf_data_r <= buf_data_r;
            end
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= RESP;
          end else if (timeout_s) begin
            mem_rdata  <= 16'h0000;
            mem_err    <= 1'b1;
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= RESP;
          end else begin
            wait_cnt_r <= (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          mem_resp <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mem_resp   <= 1'b0;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          wait_cnt_r <= '0;
          state_r    <= IDLE;
        end
      endcase
      // Invalidate overrides a fill or merge landing on the same edge.
      if (inval) begin
        buf_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// Self-checking bench for lc3b_mem_bridge: directed vector table, reset/spurious-response
// sequences, then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_lc3b_mem_bridge;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        inval;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        mem_err;
  logic [15:0] hit_count;

  lc3b_mem_bridge #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .inval(inval),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_err(mem_err), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // physical memory, word indexed
  logic [15:0] mem [0:32767];

  // reference model state
  bit          m_valid;
  logic [14:0] m_tag;
  logic [15:0] m_data;
  int          m_hits;
  bit          m_err;

  typedef struct {
    bit          inv;
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          lat;
    bit          chk_rd;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_rs;
    int          exp_ws;
    int          exp_hits;
    bit          exp_err;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit inv, bit wr, bit rd, logic [15:0] addr, logic [15:0] wdata,
                              logic [1:0] be, int lat, bit chk_rd, logic [15:0] exp_rd,
                              int exp_lat, int exp_rs, int exp_ws, int exp_hits, bit exp_err);
    vec_t v;
    v.inv = inv; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.be = be; v.lat = lat;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_rs = exp_rs;
    v.exp_ws = exp_ws; v.exp_hits = exp_hits; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [15:0] apply_be(logic [15:0] old_d, logic [15:0] new_d, logic [1:0] be);
    logic [15:0] r;
    r = old_d;
    if (be[0]) r[7:0] = new_d[7:0];
    if (be[1]) r[15:8] = new_d[15:8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_inval();
    @(negedge clk);
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
  endtask

  // Drive one CPU request and play the pmem side; lat=0 means pmem never answers.
  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be, input int lat,
                         output int o_lat, output int o_rs, output int o_ws,
                         output logic [15:0] o_rdata, output int o_bad);
    int rs;
    int ws;
    rs = 0; ws = 0; o_lat = -1; o_bad = 0; o_rdata = 16'h0000;
    @(negedge clk);
    mem_write = wr; mem_read = rd; mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
    for (int c = 1; c <= 40 && o_lat < 0; c++) begin
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'($urandom);
      if (pmem_read) rs++;
      if (pmem_write) ws++;
      if (pmem_read || pmem_write) begin
        if (pmem_address !== {addr[15:1], 1'b0}) o_bad++;
        if (pmem_write && (pmem_wdata !== wdata || pmem_byte_enable !== be)) o_bad++;
        if (lat != 0 && rs + ws == lat) begin
          pmem_resp = 1'b1;
          if (pmem_read) pmem_rdata = mem[addr[15:1]];
          else mem[addr[15:1]] = apply_be(mem[addr[15:1]], wdata, be);
        end
      end
      if (mem_resp) begin
        o_lat   = c;
        o_rdata = mem_rdata;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    o_rs = rs; o_ws = ws;
  endtask

  // Transaction-level expectation from the bridge rules; updates the model state.
  task automatic model_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input int lat,
                           output int e_lat, output int e_rs, output int e_ws,
                           output bit e_chk, output logic [15:0] e_rd);
    logic [14:0] w;
    bit ok;
    int pm;
    w = addr[15:1];
    ok = (lat >= 1 && lat <= TO);
    pm = ok ? lat : TO;
    e_rs = 0; e_ws = 0; e_chk = 1'b0; e_rd = 16'h0000;
    if (wr) begin
      e_ws = pm; e_lat = pm + 1;
      if (ok && m_valid && m_tag == w) m_data = apply_be(m_data, wdata, be);
      if (!ok) m_err = 1'b1;
    end else if (m_valid && m_tag == w) begin
      e_lat = 2; e_chk = 1'b1; e_rd = m_data;
      if (m_hits < 65535) m_hits++;
    end else begin
      e_rs = pm; e_lat = pm + 1; e_chk = 1'b1;
      if (ok) begin
        e_rd = mem[w]; m_valid = 1'b1; m_tag = w; m_data = mem[w];
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic model_check(input string tag, input bit wr, input bit rd, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be, input int lat);
    int e_lat, e_rs, e_ws, o_lat, o_rs, o_ws, o_bad;
    bit e_chk;
    logic [15:0] e_rd, o_rd;
    model_txn(wr, addr, wdata, be, lat, e_lat, e_rs, e_ws, e_chk, e_rd);
    run_txn(wr, rd, addr, wdata, be, lat, o_lat, o_rs, o_ws, o_rd, o_bad);
    check({tag, ".lat"}, o_lat, e_lat);
    check({tag, ".rstrobe"}, o_rs, e_rs);
    check({tag, ".wstrobe"}, o_ws, e_ws);
    if (e_chk) check({tag, ".rdata"}, 32'(o_rd), 32'(e_rd));
    check({tag, ".pmem_bus"}, o_bad, 0);
    check({tag, ".hits"}, 32'(hit_count), m_hits);
    check({tag, ".err"}, 32'(mem_err), 32'(m_err));
  endtask

  initial begin
    int o_lat, o_rs, o_ws, o_bad;
    logic [15:0] o_rd;
    string nm;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000; inval = 1'b0;
    pmem_rdata = 16'h0000; pmem_resp = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h1800] = 16'h1234;

    //      inv wr rd addr      wdata     be     lat chk exp_rd    lat rs ws hits err
    tbl.push_back(mk(0, 0, 1, 16'h3000, 16'h0000, 2'b00, 3, 1, 16'h1234, 4, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3001, 16'h0000, 2'b00, 1, 1, 16'h1234, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h3000, 16'hABCD, 2'b01, 1, 0, 16'h0000, 2, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3000, 16'h0000, 2'b00, 1, 1, 16'h12CD, 2, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 16'h3002, 16'h5555, 2'b11, 2, 0, 16'h0000, 3, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3000, 16'h0000, 2'b00, 1, 1, 16'h12CD, 2, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3002, 16'h0000, 2'b00, 4, 1, 16'h5555, 5, 4, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3003, 16'h0000, 2'b00, 1, 1, 16'h5555, 2, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 1, 16'h3002, 16'h0000, 2'b00, 1, 1, 16'h5555, 2, 1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 16'h3002, 16'hA0B0, 2'b10, 1, 0, 16'h0000, 2, 0, 1, 4, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3002, 16'h0000, 2'b00, 1, 1, 16'hA055, 2, 0, 0, 5, 0));
    tbl.push_back(mk(0, 1, 0, 16'h3002, 16'hFFFF, 2'b00, 1, 0, 16'h0000, 2, 0, 1, 5, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3002, 16'h0000, 2'b00, 1, 1, 16'hA055, 2, 0, 0, 6, 0));
    tbl.push_back(mk(0, 1, 1, 16'h3010, 16'h7777, 2'b11, 1, 0, 16'h0000, 2, 0, 1, 6, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3010, 16'h0000, 2'b00, 2, 1, 16'h7777, 3, 2, 0, 6, 0));
    tbl.push_back(mk(0, 0, 1, 16'h4000, 16'h0000, 2'b00, 0, 1, 16'h0000, 5, 4, 0, 6, 1));
    tbl.push_back(mk(0, 0, 1, 16'h3010, 16'h0000, 2'b00, 1, 1, 16'h7777, 2, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 16'h3010, 16'h1111, 2'b11, 0, 0, 16'h0000, 5, 0, 4, 7, 1));
    tbl.push_back(mk(0, 0, 1, 16'h3011, 16'h0000, 2'b00, 1, 1, 16'h7777, 2, 0, 0, 8, 1));

    repeat (3) @(negedge clk);
    check("rst.mem_rdata", 32'(mem_rdata), 32'h0);
    check("rst.mem_resp", 32'(mem_resp), 32'h0);
    check("rst.pmem_read", 32'(pmem_read), 32'h0);
    check("rst.pmem_write", 32'(pmem_write), 32'h0);
    check("rst.pmem_address", 32'(pmem_address), 32'h0);
    check("rst.pmem_wdata", 32'(pmem_wdata), 32'h0);
    check("rst.pmem_be", 32'(pmem_byte_enable), 32'h0);
    check("rst.mem_err", 32'(mem_err), 32'h0);
    check("rst.hit_count", 32'(hit_count), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].inv) pulse_inval();
      run_txn(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].lat,
              o_lat, o_rs, o_ws, o_rd, o_bad);
      nm = $sformatf("v%0d", i);
      check({nm, ".lat"}, o_lat, tbl[i].exp_lat);
      check({nm, ".rstrobe"}, o_rs, tbl[i].exp_rs);
      check({nm, ".wstrobe"}, o_ws, tbl[i].exp_ws);
      if (tbl[i].chk_rd) check({nm, ".rdata"}, 32'(o_rd), 32'(tbl[i].exp_rd));
      check({nm, ".pmem_bus"}, o_bad, 0);
      check({nm, ".hits"}, 32'(hit_count), tbl[i].exp_hits);
      check({nm, ".err"}, 32'(mem_err), 32'(tbl[i].exp_err));
    end

    // reset asserted while a read is waiting on pmem
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h3000;
    @(negedge clk);
    @(negedge clk);
    check("midrst.pmem_read_before", 32'(pmem_read), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst.pmem_read", 32'(pmem_read), 32'h0);
    check("midrst.mem_resp", 32'(mem_resp), 32'h0);
    check("midrst.mem_err", 32'(mem_err), 32'h0);
    check("midrst.hit_count", 32'(hit_count), 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_tag = 15'h0000; m_data = 16'h0000; m_hits = 0; m_err = 1'b0;
    check("midrst.mem_model", 32'(mem[15'h1800]), 32'h12CD);
    model_check("postrst", 1'b0, 1'b1, 16'h3000, 16'h0000, 2'b00, 2);

    // pmem_resp while idle must not complete anything or touch the buffer
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("spurious%0d.mem_resp", k), 32'(mem_resp), 32'h0);
    end
    pmem_resp = 1'b0;
    model_check("spurious.hit", 1'b0, 1'b1, 16'h3001, 16'h0000, 2'b00, 1);

    // randomized traffic over a small address window so hits, merges and misses mix
    for (int n = 0; n < 200; n++) begin
      bit wr, rd;
      int lat;
      logic [15:0] addr;
      if ($urandom_range(0, 9) == 0) begin
        pulse_inval();
        m_valid = 1'b0;
      end
      wr   = ($urandom_range(0, 9) < 3);
      rd   = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      addr = 16'h5000 + 16'($urandom_range(0, 7));
      lat  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, TO));
      model_check($sformatf("r%0d", n), wr, rd, addr, 16'($urandom), 2'($urandom), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
